// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for serial_add_sub.
// The master drives the request; the slave (the adder) returns status and results.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, a, b, ci,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, sub, a, b, ci,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// WIDTH-bit adder/subtractor that walks the operands LSB-first, SLICE bits per
// clock, through one shared SLICE-bit carry chain, with start/busy/done handshake.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input logic             clk,
  input logic             nrst,
  serial_add_sub_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("serial_add_sub: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_next, s_r;
  logic             carry, co_r, ovf_r, done_r;
  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             c_out, c_msb, last;

  // Operands shift right each cycle, so the active slice is always the low bits;
  // sum slices enter the accumulator from the top and land in place after N steps.
  always_comb begin
    a_sl            = op_a[SLICE-1:0];
    b_sl            = op_b[SLICE-1:0];
    {c_out, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
    // Carry into the top bit of the slice falls out of that bit's sum: s = a ^ b ^ cin.
    c_msb           = sum_sl[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];
    acc_next        = WIDTH'({sum_sl, acc} >> SLICE);
    last            = (cnt == CW'(N - 1));
    next_state      = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (last)      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      s_r    <= '0;
      co_r   <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.ci;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          op_a  <= op_a >> SLICE;
          op_b  <= op_b >> SLICE;
          carry <= c_out;
          acc   <= acc_next;
          cnt   <= cnt + 1'b1;
          if (last) begin
            s_r    <= acc_next;
            co_r   <= c_out;
            ovf_r  <= c_msb ^ c_out;
            done_r <= 1'b1;
            cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.co   = co_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed vector table, handshake corner sequences,
// and a randomized sweep over several WIDTH/SLICE pairs against an arithmetic model.
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Directed DUTs: 8-bit bit-serial and 8-bit nibble-serial.
  logic       st81, st84, vsub, vci;
  logic [7:0] va, vb;
  int         sel;

  serial_add_sub_if #(.WIDTH(8)) if81();
  serial_add_sub_if #(.WIDTH(8)) if84();

  assign if81.start = st81;
  assign if81.sub   = vsub;
  assign if81.a     = va;
  assign if81.b     = vb;
  assign if81.ci    = vci;
  assign if84.start = st84;
  assign if84.sub   = vsub;
  assign if84.a     = va;
  assign if84.b     = vb;
  assign if84.ci    = vci;

  serial_add_sub #(.WIDTH(8), .SLICE(1)) u81 (.clk(clk), .nrst(nrst), .bus(if81.slave));
  serial_add_sub #(.WIDTH(8), .SLICE(4)) u84 (.clk(clk), .nrst(nrst), .bus(if84.slave));

  logic       m_busy, m_done, m_co, m_ovf;
  logic [7:0] m_s;
  always_comb begin
    if (sel == 1) begin
      m_busy = if84.busy; m_done = if84.done; m_s = if84.s; m_co = if84.co; m_ovf = if84.ovf;
    end else begin
      m_busy = if81.busy; m_done = if81.done; m_s = if81.s; m_co = if81.co; m_ovf = if81.ovf;
    end
  end

  // Random sweep instances: W in {8,16}, S in {1,2,W}.
  bit rand_go = 1'b0;
  bit rand_fin [6];

  for (genvar g = 0; g < 6; g++) begin : g_rand
    localparam int W  = (g < 3) ? 8 : 16;
    localparam int S  = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : W);
    localparam int NS = W / S;

    serial_add_sub_if #(.WIDTH(W)) rbus();
    serial_add_sub #(.WIDTH(W), .SLICE(S)) u_rand (.clk(clk), .nrst(nrst), .bus(rbus.slave));

    initial begin
      logic [W-1:0] ra, rb, es;
      logic         rsub, rci, eco, eov;
      longint       ua, ub, ur, sa, sb, sr;
      int           lat, bsy;
      rbus.start = 1'b0; rbus.sub = 1'b0; rbus.a = '0; rbus.b = '0; rbus.ci = 1'b0;
      rand_fin[g] = 1'b0;
      wait (rand_go);
      @(negedge clk);
      for (int n = 0; n < 170; n++) begin
        if ($urandom % 3 == 0) @(negedge clk);
        ra   = W'($urandom);
        rb   = W'($urandom);
        rsub = 1'($urandom);
        rci  = 1'($urandom);
        ua   = longint'(ra);
        ub   = longint'(rb);
        sa   = $signed(ra);
        sb   = $signed(rb);
        if (rsub) begin
          ur = ua - ub + (longint'(1) << W);
          sr = sa - sb;
        end else begin
          ur = ua + ub + longint'(rci);
          sr = sa + sb + longint'(rci);
        end
        es  = W'(ur);
        eco = ur[W];
        eov = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));

        rbus.sub = rsub; rbus.a = ra; rbus.b = rb; rbus.ci = rci; rbus.start = 1'b1;
        @(negedge clk);
        // Busy now: inputs and start are scrambled and must have no effect.
        rbus.start = 1'($urandom);
        rbus.a = W'($urandom); rbus.b = W'($urandom);
        rbus.sub = 1'($urandom); rbus.ci = 1'($urandom);
        lat = 0; bsy = 0;
        while (!rbus.done && lat < 100) begin
          if (rbus.busy) bsy++;
          @(negedge clk);
          rbus.start = 1'b0;
          lat++;
        end
        check($sformatf("rand_w%0d_s%0d_sum", W, S), 32'(rbus.s), 32'(es));
        check($sformatf("rand_w%0d_s%0d_co", W, S), 32'(rbus.co), 32'(eco));
        check($sformatf("rand_w%0d_s%0d_ovf", W, S), 32'(rbus.ovf), 32'(eov));
        check($sformatf("rand_w%0d_s%0d_latency", W, S), 32'(lat), 32'(NS));
        check($sformatf("rand_w%0d_s%0d_busy_cycles", W, S), 32'(bsy), 32'(NS));
      end
      rand_fin[g] = 1'b1;
    end
  end

  typedef struct {
    logic       sub;
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic op(input int which, input logic sb_i, input logic [7:0] a_i, b_i,
                    input logic c_i, output logic [7:0] rs, output logic rco, rov,
                    output int lat, output int bsy);
    sel = which;
    @(negedge clk);
    vsub = sb_i; va = a_i; vb = b_i; vci = c_i;
    if (which == 1) st84 = 1'b1; else st81 = 1'b1;
    @(negedge clk);
    st81 = 1'b0; st84 = 1'b0;
    va = 8'($urandom); vb = 8'($urandom); vsub = 1'($urandom); vci = 1'($urandom);
    lat = 0; bsy = 0;
    while (!m_done && lat < 50) begin
      if (m_busy) bsy++;
      @(negedge clk);
      lat++;
    end
    rs = m_s; rco = m_co; rov = m_ovf;
  endtask

  initial begin
    logic [7:0] rs;
    logic       rco, rov;
    int         lat, bsy, nd, nfin;

    tbl[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};

    nrst = 1'b0; st81 = 1'b0; st84 = 1'b0; vsub = 1'b0; vci = 1'b0;
    va = 8'h00; vb = 8'h00; sel = 0;
    repeat (3) @(negedge clk);
    check("reset_81", {if81.busy, if81.done, if81.co, if81.ovf, if81.s}, 32'h0);
    check("reset_84", {if84.busy, if84.done, if84.co, if84.ovf, if84.s}, 32'h0);
    nrst = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        op(d, tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].ci, rs, rco, rov, lat, bsy);
        check($sformatf("vec_d%0d_%0d_s", d, i), 32'(rs), 32'(tbl[i].s));
        check($sformatf("vec_d%0d_%0d_co", d, i), 32'(rco), 32'(tbl[i].co));
        check($sformatf("vec_d%0d_%0d_ovf", d, i), 32'(rov), 32'(tbl[i].ovf));
        check($sformatf("vec_d%0d_%0d_latency", d, i), 32'(lat), (d == 1) ? 32'd2 : 32'd8);
        check($sformatf("vec_d%0d_%0d_busy_cycles", d, i), 32'(bsy), (d == 1) ? 32'd2 : 32'd8);
        check($sformatf("vec_d%0d_%0d_busy_at_done", d, i), 32'(m_busy), 32'd0);
      end
    end

    // Start pulsed mid-operation is ignored; start in the done cycle is accepted.
    sel = 0;
    @(negedge clk);
    vsub = 1'b0; va = 8'h12; vb = 8'h34; vci = 1'b0; st81 = 1'b1;
    @(negedge clk);
    st81 = 1'b0; nd = 0;
    for (int i = 1; i <= 8; i++) begin
      if (m_done) nd++;
      st81 = (i == 3);
      if (i == 3) begin va = 8'hFF; vb = 8'hFF; vci = 1'b1; end
      @(negedge clk);
    end
    check("busy_start_early_done", 32'(nd), 32'd0);
    check("busy_start_done", 32'(m_done), 32'd1);
    check("busy_start_s", 32'(m_s), 32'h46);
    check("busy_start_co_ovf", {m_co, m_ovf}, 32'd0);
    vsub = 1'b1; va = 8'h10; vb = 8'h01; vci = 1'b0; st81 = 1'b1;
    @(negedge clk);
    st81 = 1'b0;
    check("b2b_busy_no_gap", 32'(m_busy), 32'd1);
    check("b2b_no_done_pulse", 32'(m_done), 32'd0);
    lat = 0;
    while (!m_done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", 32'(lat), 32'd8);
    check("b2b_s", 32'(m_s), 32'h0F);
    check("b2b_co_ovf", {m_co, m_ovf}, 32'b10);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    vsub = 1'b0; va = 8'hFF; vb = 8'h01; vci = 1'b0; st81 = 1'b1;
    @(negedge clk);
    st81 = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(m_busy), 32'd0);
    check("abort_done", 32'(m_done), 32'd0);
    check("abort_s", 32'(m_s), 32'd0);
    check("abort_co_ovf", {m_co, m_ovf}, 32'd0);
    nrst = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_done) nd++;
    end
    check("abort_no_late_done", 32'(nd), 32'd0);
    op(0, 1'b0, 8'h55, 8'h2A, 1'b1, rs, rco, rov, lat, bsy);
    check("after_abort_s", 32'(rs), 32'h80);
    check("after_abort_co_ovf", {rco, rov}, 32'b01);
    check("after_abort_latency", 32'(lat), 32'd8);

    rand_go = 1'b1;
    nfin = 0;
    for (int t = 0; t < 20000 && nfin < 6; t++) begin
      @(negedge clk);
      nfin = 0;
      for (int g = 0; g < 6; g++) if (rand_fin[g]) nfin++;
    end
    check("rand_sweeps_finished", 32'(nfin), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
